// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: state encoding and the
// helper that picks the next layer to run from a bypass mask.
package cnn_seq_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_START   = S_START,
        ST_WAIT    = S_WAIT,
        ST_DONE    = S_DONE,
        ST_ERROR   = S_ERROR,
        ST_RELEASE = S_RELEASE
    } state_t;

    // Upper bound on NUM_LAYERS; the search works on a zero-extended mask.
    localparam int MAX_LAYERS = 32;

    typedef struct packed {
        logic none;
        int   idx;
    } layer_sel_t;

    // Lowest non-skipped index in [from, num); none=1 when every candidate is skipped.
    function automatic layer_sel_t next_active(input logic [MAX_LAYERS-1:0] skip,
                                               input int num, input int from);
        layer_sel_t sel;
        sel.none = 1'b1;
        sel.idx  = 0;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (i >= from && i < num && !skip[i]) begin
                sel.none = 1'b0;
                sel.idx  = i;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Layer-side bus of the sequencer: per-layer start pulses, done levels and
// the final layer's result.
interface cnn_layer_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int DATA_W     = 32
);
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [DATA_W-1:0]     result_in;

    modport master (
        output layer_start,
        input  layer_done,
        input  result_in
    );

    modport slave (
        input  layer_start,
        output layer_done,
        output result_in
    );
endinterface

// File: rtl/seq_watchdog.sv
// Per-layer watchdog: counts while enabled, flags expiry one cycle before the
// count reaches the limit; a zero limit disables it.
module seq_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] count_reg;
    logic [TMO_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_en && count_reg != '1) begin
            count_next = count_reg + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // >= rather than == so a limit of 1 still fires on the first wait cycle.
    assign expire = (limit != '0) && (count_reg >= limit - TMO_W'(1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs NUM_LAYERS compute layers in index order over a start-pulse / done-level
// handshake, with bypass, watchdog, abort, re-arm and run-cycle counting.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int  NUM_LAYERS = 3,
    parameter int  DATA_W     = 32,
    parameter int  TMO_W      = 16,
    parameter int  CNT_W      = 24,
    localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_bypass,
    input  logic [TMO_W-1:0]      timeout_cycles,
    cnn_layer_sequencer_if.master lbus,
    output logic [LW-1:0]         cur_layer,
    output logic                  busy,
    output logic [DATA_W-1:0]     value,
    output logic                  done,
    output logic                  error,
    output logic [LW-1:0]         err_layer,
    output logic [CNT_W-1:0]      run_cycles
);

    state_t                state_reg, state_next;
    logic [LW-1:0]         cur_reg, cur_next;
    logic [NUM_LAYERS-1:0] mask_reg, mask_next;
    logic [TMO_W-1:0]      tmo_reg, tmo_next;
    logic [DATA_W-1:0]     value_reg, value_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;
    logic [LW-1:0]         err_layer_reg, err_layer_next;
    logic [CNT_W-1:0]      run_reg, run_next;
    logic                  busy_reg, busy_next;
    logic [NUM_LAYERS-1:0] start_reg, start_next;
    layer_sel_t            first_sel, later_sel;
    logic                  wd_expire;

    seq_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_next == ST_START),
        .count_en (state_reg == ST_START || state_reg == ST_WAIT),
        .limit    (tmo_reg),
        .expire   (wd_expire)
    );

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        mask_next      = mask_reg;
        tmo_next       = tmo_reg;
        value_next     = value_reg;
        error_next     = error_reg;
        err_layer_next = err_layer_reg;
        run_next       = run_reg;
        first_sel      = next_active(MAX_LAYERS'(layer_bypass), NUM_LAYERS, 0);
        later_sel      = next_active(MAX_LAYERS'(mask_reg), NUM_LAYERS, int'(cur_reg) + 1);

        // Abort freezes the counter on the very edge it is seen.
        if ((state_reg == ST_START || state_reg == ST_WAIT) && !abort && run_reg != '1) begin
            run_next = run_reg + CNT_W'(1);
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (!abort && enable) begin
                    mask_next  = layer_bypass;
                    tmo_next   = timeout_cycles;
                    error_next = 1'b0;
                    run_next   = '0;
                    if (first_sel.none) begin
                        state_next = ST_DONE;
                    end else begin
                        cur_next   = LW'(first_sel.idx);
                        state_next = ST_START;
                    end
                end
            end
            ST_START: begin
                state_next = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (lbus.layer_done[cur_reg]) begin
                    if (later_sel.none) begin
                        value_next = lbus.result_in;
                        state_next = ST_DONE;
                    end else begin
                        cur_next   = LW'(later_sel.idx);
                        state_next = ST_START;
                    end
                end else if (wd_expire) begin
                    error_next     = 1'b1;
                    err_layer_next = cur_reg;
                    state_next     = ST_ERROR;
                end
            end
            ST_DONE: begin
                state_next = ST_RELEASE;
            end
            ST_ERROR: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (!enable) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        done_next = (state_next == ST_DONE);
        busy_next = (state_next != ST_IDLE) && (state_next != ST_RELEASE);
    end

    // Start pulses are decoded from the next state so they come out of a register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_start_dec
            assign start_next[gi] = (state_next == ST_START) && (cur_next == LW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cur_reg       <= '0;
            mask_reg      <= '0;
            tmo_reg       <= '0;
            value_reg     <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            err_layer_reg <= '0;
            run_reg       <= '0;
            busy_reg      <= 1'b0;
            start_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            mask_reg      <= mask_next;
            tmo_reg       <= tmo_next;
            value_reg     <= value_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            err_layer_reg <= err_layer_next;
            run_reg       <= run_next;
            busy_reg      <= busy_next;
            start_reg     <= start_next;
        end
    end

    assign lbus.layer_start = start_reg;
    assign cur_layer        = cur_reg;
    assign busy             = busy_reg;
    assign value            = value_reg;
    assign done             = done_reg;
    assign error            = error_reg;
    assign err_layer        = err_layer_reg;
    assign run_cycles       = run_reg;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: a cycle-stepped layer model plus a
// scoreboard of expected start/done events, values and run lengths.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;

    localparam int NL = 3;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int CW = 24;
    localparam int EV_DONE = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_bypass = '0;
    logic [TW-1:0] timeout_cycles = '0;
    logic [1:0]    cur_layer;
    logic [1:0]    err_layer;
    logic          busy, done, error;
    logic [DW-1:0] value;
    logic [CW-1:0] run_cycles;

    cnn_layer_sequencer_if #(.NUM_LAYERS(NL), .DATA_W(DW)) lbus ();

    cnn_layer_sequencer #(
        .NUM_LAYERS (NL),
        .DATA_W     (DW),
        .TMO_W      (TW),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .abort          (abort),
        .layer_bypass   (layer_bypass),
        .timeout_cycles (timeout_cycles),
        .lbus           (lbus),
        .cur_layer      (cur_layer),
        .busy           (busy),
        .value          (value),
        .done           (done),
        .error          (error),
        .err_layer      (err_layer),
        .run_cycles     (run_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = -1;
    int en_cyc = 0;
    int err_cyc = 0;
    int dc = 0;
    int lat[NL];
    int rem[NL];
    int st_cyc[NL];
    int            exp_ev[$];
    logic [DW-1:0] exp_val[$];
    int            exp_rc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pop_ev();
        if (exp_ev.size() == 0) return -2;
        return exp_ev.pop_front();
    endfunction

    function automatic logic [DW-1:0] pop_val();
        if (exp_val.size() == 0) return 'x;
        return exp_val.pop_front();
    endfunction

    function automatic int pop_rc();
        if (exp_rc.size() == 0) return -2;
        return exp_rc.pop_front();
    endfunction

    task automatic push_run(input int n0, input int n1, input int n2, input logic [DW-1:0] v, input int rc);
        if (n0 >= 0) exp_ev.push_back(n0);
        if (n1 >= 0) exp_ev.push_back(n1);
        if (n2 >= 0) exp_ev.push_back(n2);
        exp_ev.push_back(EV_DONE);
        exp_val.push_back(v);
        exp_rc.push_back(rc);
    endtask

    task automatic clr_st();
        for (int i = 0; i < NL; i++) st_cyc[i] = -1;
    endtask

    // One clock: advance the layer model, then score whatever the DUT emitted.
    task automatic tick();
        int ev;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NL; i++) begin
            if (rem[i] > 0) rem[i]--;
            if (rem[i] == 0) begin
                lbus.layer_done[i] = 1'b1;
                rem[i] = -1;
            end
        end
        if (lbus.layer_start != '0 || done) begin
            ev = 99;
            if (done) ev = (lbus.layer_start != '0) ? 98 : EV_DONE;
            else if ($onehot(lbus.layer_start)) begin
                for (int i = 0; i < NL; i++) if (lbus.layer_start[i]) ev = i;
            end
            $display("cyc %0d event %0d value=%h run_cycles=%0d", cyc, ev, value, run_cycles);
            check("event_order", ev, pop_ev());
            for (int i = 0; i < NL; i++) begin
                if (lbus.layer_start[i]) begin
                    st_cyc[i] = cyc;
                    if (lat[i] != 0) begin
                        lbus.layer_done[i] = 1'b0;
                        rem[i] = lat[i];
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("done_value", value, pop_val());
                check("done_run_cycles", run_cycles, pop_rc());
            end
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = done_count;
        int k = 0;
        while (done_count == n && k < budget) begin
            tick();
            k++;
        end
        check(tag, done_count - n, 1);
    endtask

    task automatic wait_start(input int idx, input int budget, input string tag);
        int k = 0;
        while (st_cyc[idx] < 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, st_cyc[idx] >= 0, 1);
    endtask

    task automatic release_enable();
        tick();
        enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        lbus.layer_done = '0;
        lbus.result_in  = '0;
        for (int i = 0; i < NL; i++) begin
            lat[i] = 1;
            rem[i] = -1;
        end
        clr_st();

        // Reset state
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_value", value, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_start", lbus.layer_start, 0);
        check("rst_cur_layer", cur_layer, 0);
        check("rst_err_layer", err_layer, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();

        // 1: full run, latencies 5/7/3
        lat = '{5, 7, 3};
        lbus.result_in = 32'hDEAD_BEEF;
        clr_st();
        push_run(0, 1, 2, 32'hDEAD_BEEF, 18);
        enable = 1'b1;
        en_cyc = cyc;
        wait_done(100, "t1_done_seen");
        check("t1_start0_latency", st_cyc[0] - en_cyc, 1);
        check("t1_gap_0_1", st_cyc[1] - st_cyc[0], 6);
        check("t1_gap_1_2", st_cyc[2] - st_cyc[1], 8);
        check("t1_done_after_2", done_cyc - st_cyc[2], 4);
        check("t1_cur_layer", cur_layer, 2);
        tick();
        check("t1_done_width", done, 0);
        check("t1_busy_release", busy, 0);
        check("t1_value_hold", value, 32'hDEAD_BEEF);
        enable = 1'b0;
        tick();
        tick();

        // 2a: layer 1 bypassed
        layer_bypass = 3'b010;
        lbus.result_in = 32'h1234_5678;
        clr_st();
        push_run(0, 2, -1, 32'h1234_5678, 10);
        enable = 1'b1;
        wait_done(100, "t2a_done_seen");
        check("t2a_no_start1", st_cyc[1], -1);
        check("t2a_gap_0_2", st_cyc[2] - st_cyc[0], 6);
        release_enable();

        // 2b: everything bypassed, value must not move
        layer_bypass = 3'b111;
        lbus.result_in = 32'hAAAA_5555;
        clr_st();
        push_run(-1, -1, -1, 32'h1234_5678, 0);
        enable = 1'b1;
        en_cyc = cyc;
        wait_done(10, "t2b_done_seen");
        check("t2b_done_latency", done_cyc - en_cyc, 1);
        check("t2b_no_starts", (st_cyc[0] < 0) && (st_cyc[1] < 0) && (st_cyc[2] < 0), 1);
        release_enable();
        layer_bypass = '0;

        // 3: watchdog on layer 1
        lat = '{5, 0, 3};
        lbus.layer_done[1] = 1'b0;
        timeout_cycles = 16'd10;
        lbus.result_in = 32'h0F0F_0F0F;
        clr_st();
        exp_ev.push_back(0);
        exp_ev.push_back(1);
        dc = done_count;
        enable = 1'b1;
        begin
            int k = 0;
            while (!error && k < 100) begin
                tick();
                k++;
            end
        end
        err_cyc = cyc;
        check("t3_error_seen", error, 1);
        check("t3_error_latency", err_cyc - st_cyc[1], 10);
        check("t3_err_layer", err_layer, 1);
        check("t3_busy_in_error", busy, 1);
        tick();
        tick();
        check("t3_error_sticky", error, 1);
        check("t3_no_done", done_count - dc, 0);
        enable = 1'b0;
        tick();
        check("t3_busy_after_release", busy, 0);
        check("t3_error_kept", error, 1);
        tick();
        lat = '{3, 3, 3};
        timeout_cycles = '0;
        lbus.result_in = 32'hCAFE_F00D;
        clr_st();
        push_run(0, 1, 2, 32'hCAFE_F00D, 12);
        enable = 1'b1;
        tick();
        check("t3_error_cleared", error, 0);
        wait_done(100, "t3b_done_seen");
        release_enable();

        // 4: abort in layer 1 wait
        lat = '{2, 9, 2};
        lbus.result_in = 32'h0BAD_0BAD;
        clr_st();
        exp_ev.push_back(0);
        exp_ev.push_back(1);
        dc = done_count;
        enable = 1'b1;
        wait_start(1, 50, "t4_start1_seen");
        tick();
        tick();
        tick();
        abort = 1'b1;
        enable = 1'b0;
        tick();
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        check("t4_start_after_abort", lbus.layer_start, 0);
        check("t4_value_kept", value, 32'hCAFE_F00D);
        check("t4_run_cycles_frozen", run_cycles, 6);
        repeat (12) tick();
        check("t4_no_done", done_count - dc, 0);
        check("t4_idle", busy, 0);

        // 5: held enable gives one run; re-arm gives another
        lat = '{1, 1, 1};
        lbus.result_in = 32'h5A5A_5A5A;
        clr_st();
        push_run(0, 1, 2, 32'h5A5A_5A5A, 6);
        dc = done_count;
        enable = 1'b1;
        repeat (100) tick();
        check("t5_single_done", done_count - dc, 1);
        enable = 1'b0;
        tick();
        tick();
        push_run(0, 1, 2, 32'h5A5A_5A5A, 6);
        enable = 1'b1;
        wait_done(50, "t5_rearm_done_seen");
        check("t5_two_dones", done_count - dc, 2);
        release_enable();

        // 6a: asynchronous reset in the middle of a wait
        lat = '{5, 7, 3};
        lbus.result_in = 32'h1111_2222;
        clr_st();
        exp_ev.push_back(0);
        exp_ev.push_back(1);
        enable = 1'b1;
        wait_start(1, 50, "t6_start1_seen");
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_start", lbus.layer_start, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cur_layer", cur_layer, 0);
        check("t6_rst_value", value, 0);
        check("t6_rst_run_cycles", run_cycles, 0);
        check("t6_rst_error", error, 0);
        enable = 1'b0;
        lbus.layer_done = '0;
        for (int i = 0; i < NL; i++) rem[i] = -1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("t6_idle_after_rst", busy, 0);

        // 6b: done already high during START is only taken in WAIT
        lat = '{0, 2, 2};
        lbus.layer_done[0] = 1'b1;
        lbus.result_in = 32'h7777_0001;
        clr_st();
        push_run(0, 1, 2, 32'h7777_0001, 8);
        enable = 1'b1;
        wait_done(50, "t6b_done_seen");
        check("t6b_gap_0_1", st_cyc[1] - st_cyc[0], 2);
        release_enable();

        check("scoreboard_empty", exp_ev.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
